// File: rtl/tick_divider_pkg.sv
// Shared defaults and types for the tick divider bank.
package tick_divider_pkg;
  localparam int CNT_W_DEF        = 28;
  localparam int DEFAULT_HALF_DEF = 10_000_000;
  localparam int NUM_CH_MAX       = 16;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/tick_divider_bank_if.sv
// Half-period configuration bus: write strobe, channel index and value.
interface tick_divider_bank_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = tick_divider_pkg::CNT_W_DEF
);
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;

  modport master (output cfg_we, output cfg_ch, output cfg_half);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_half);
endinterface

// File: rtl/tick_divider_ch.sv
// One divider channel: half-period register, counter, toggling output and tick strobe.
// Priority: reset, sync, write, run/hold; all outputs are registered.
module tick_divider_ch
  import tick_divider_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             div_clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    if (sync_i) begin
      cnt_d = '0;
      div_d = 1'b0;
    end else if (we_i) begin
      // A write restarts the count but keeps the output level.
      half_d = half_i;
      cnt_d  = '0;
    end else if (en_i) begin
      if (cnt_q == half_q) begin
        cnt_d  = '0;
        div_d  = ~div_q;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_q <= CNT_W'(DEFAULT_HALF);
      cnt_q  <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign div_clk_o = div_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Multi-channel programmable divider: write decode, range check and sync fan-out over NUM_CH channels.
// Optional global phase realign via sync_pulse when TICK_DIVIDER_SYNC_EN is defined.
module tick_divider_bank
  import tick_divider_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  tick_divider_bank_if.slave  cfg,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                sync_pulse,
  output logic [NUM_CH-1:0]   divided_clk,
  output logic [NUM_CH-1:0]   tick
);

  if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("tick_divider_bank: NUM_CH out of range");
  end

  logic cfg_ok;
  logic sync_all;

  assign cfg_ok = cfg.cfg_we && (32'(cfg.cfg_ch) < 32'(NUM_CH));

`ifdef TICK_DIVIDER_SYNC_EN
  assign sync_all = sync_pulse;
`else
  // Port kept for a uniform instantiation; the channels see a constant zero.
  logic unused_sync;
  assign unused_sync = sync_pulse;
  assign sync_all    = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;
    assign we_ch = cfg_ok && (cfg.cfg_ch == CH_W'(i));

    tick_divider_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_i     (clk_in),
      .rst_i     (rst),
      .en_i      (ch_en[i]),
      .sync_i    (sync_all),
      .we_i      (we_ch),
      .half_i    (cfg.cfg_half),
      .div_clk_o (divided_clk[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank: 3 channels, 8-bit counters, reset half-period 3.
module tb_tick_divider_bank;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DH  = 3;
  localparam int CHW = 2;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_en;
  logic           sync_pulse;
  logic [NCH-1:0] divided_clk;
  logic [NCH-1:0] tick;

  tick_divider_bank_if #(.CH_W(CHW), .CNT_W(CW)) cfg_if ();

  tick_divider_bank #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(DH), .CH_W(CHW)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .cfg         (cfg_if.slave),
    .ch_en       (ch_en),
    .sync_pulse  (sync_pulse),
    .divided_clk (divided_clk),
    .tick        (tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int nw2    = 0;

  task automatic step();
    @(posedge clk_in);
    #1;
    n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ch1 (half 0) and ch2 (half 5) written at edge nw2 and never touched again.
  task automatic chk_model(input string tag);
    int j;
    j = n - nw2;
    chk({tag, "_dc1"},   32'(divided_clk[1]), 32'((j % 2) == 0));
    chk({tag, "_tick1"}, 32'(tick[1]),        32'd1);
    chk({tag, "_dc2"},   32'(divided_clk[2]), 32'((j / 6) % 2));
    chk({tag, "_tick2"}, 32'(tick[2]),        32'((j % 6) == 0));
  endtask

  task automatic write(input logic [CHW-1:0] ch, input logic [CW-1:0] half);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_ch   = ch;
    cfg_if.cfg_half = half;
  endtask

  task automatic write_off();
    cfg_if.cfg_we = 1'b0;
  endtask

  initial begin
    logic [11:0] dc0_tab;
    logic [11:0] tk0_tab;
    rst        = 1'b1;
    ch_en      = 3'b111;
    sync_pulse = 1'b0;
    // A write during reset must be overridden.
    write(2'd0, 8'd0);

    // Reset
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_dc", 32'(divided_clk), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
    end
    rst = 1'b0;
    write_off();

    // First toggle 4 edges after release, period 8
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("run_dc", 32'(divided_clk), (k >= 4 && k < 8) ? 32'h7 : 32'h0);
      chk("run_tick", 32'(tick), (k == 4 || k == 8) ? 32'h7 : 32'h0);
    end

    // Write ch1 half=0, then ch2 half=5
    write(2'd1, 8'd0);
    step();
    chk("w1_dc", 32'(divided_clk), 32'h0);
    chk("w1_tick", 32'(tick), 32'h0);
    write(2'd2, 8'd5);
    step();
    nw2 = n;
    write_off();
    chk("w2_dc", 32'(divided_clk), 32'h2);
    chk("w2_tick", 32'(tick), 32'h2);

    // ch0 (half 3, cnt 2 after W2) toggles at j = 2, 6, 10; bit index = j-1
    dc0_tab = 12'b1110_0001_1110;
    tk0_tab = 12'b0010_0010_0010;
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("mix_dc0", 32'(divided_clk[0]), 32'(dc0_tab[j-1]));
      chk("mix_tick0", 32'(tick[0]), 32'(tk0_tab[j-1]));
      chk_model("mix");
    end

    // Hold ch0 at cnt=2 for 10 edges
    ch_en = 3'b110;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_dc0", 32'(divided_clk[0]), 32'd1);
      chk("hold_tick0", 32'(tick[0]), 32'd0);
      chk_model("hold");
    end
    ch_en = 3'b111;
    step();
    chk("resume1_dc0", 32'(divided_clk[0]), 32'd1);
    chk("resume1_tick0", 32'(tick[0]), 32'd0);
    step();
    chk("resume2_dc0", 32'(divided_clk[0]), 32'd0);
    chk("resume2_tick0", 32'(tick[0]), 32'd1);
    chk_model("resume");

    // Write ch0 half=2 on its terminal-count edge
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pre_tc_dc0", 32'(divided_clk[0]), 32'd0);
      chk("pre_tc_tick0", 32'(tick[0]), 32'd0);
    end
    write(2'd0, 8'd2);
    step();
    write_off();
    chk("tc_wr_dc0", 32'(divided_clk[0]), 32'd0);
    chk("tc_wr_tick0", 32'(tick[0]), 32'd0);
    chk_model("tc_wr");
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("new_half_dc0", 32'(divided_clk[0]), (k >= 3 && k < 6) ? 32'd1 : 32'd0);
      chk("new_half_tick0", 32'(tick[0]), (k == 3 || k == 6) ? 32'd1 : 32'd0);
      chk_model("new_half");
    end

    // Out-of-range channel index: no channel may change
    write(2'd3, 8'd0);
    step();
    write_off();
    chk("oor_dc0", 32'(divided_clk[0]), 32'd0);
    chk("oor_tick0", 32'(tick[0]), 32'd0);
    chk_model("oor");
    for (int k = 2; k <= 7; k++) begin
      step();
      chk("oor_run_dc0", 32'(divided_clk[0]), (k >= 3 && k < 6) ? 32'd1 : 32'd0);
      chk("oor_run_tick0", 32'(tick[0]), (k == 3 || k == 6) ? 32'd1 : 32'd0);
      chk_model("oor_run");
    end

    // Sync pulse at mixed phases (ch0 cnt=1)
    sync_pulse = 1'b1;
    step();
    sync_pulse = 1'b0;
`ifdef TICK_DIVIDER_SYNC_EN
    chk("sync_dc", 32'(divided_clk), 32'h0);
    chk("sync_tick", 32'(tick), 32'h0);
    step();
    chk("sync1_dc", 32'(divided_clk), 32'h2);
    chk("sync1_tick", 32'(tick), 32'h2);
    step();
    chk("sync2_dc", 32'(divided_clk), 32'h0);
    chk("sync2_tick", 32'(tick), 32'h2);
    step();
    chk("sync3_dc", 32'(divided_clk), 32'h3);
    chk("sync3_tick", 32'(tick), 32'h3);
`else
    chk("nosync_dc0", 32'(divided_clk[0]), 32'd0);
    chk("nosync_tick0", 32'(tick[0]), 32'd0);
    chk_model("nosync");
    step();
    chk("nosync1_dc0", 32'(divided_clk[0]), 32'd1);
    chk("nosync1_tick0", 32'(tick[0]), 32'd1);
    chk_model("nosync1");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_divider_bank.md
# tick_divider_bank

Multi-channel programmable clock divider that generates several independent slow toggle outputs plus single-cycle tick strobes from one fast system clock. Each channel has a runtime-writable half-period and its own enable. The bank drives display multiplexing, blink, and game-timer logic from one block instead of one fixed-ratio divider per consumer.

## Interface
- `NUM_CH`, default 4: number of independent channels, 1..16.
- `CNT_W`, default 28: counter and half-period width in bits.
- `DEFAULT_HALF`, default 10_000_000: half-period loaded into every channel at reset. Must fit in `CNT_W`.
- `CH_W`, default `$clog2(NUM_CH)` with a minimum of 1: width of the channel index.

- `clk_in` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ch_en` in NUM_CH: per-channel run enable.
- `cfg_we` in 1: one-cycle write strobe for the half-period.
- `cfg_ch` in CH_W: target channel for the write.
- `cfg_half` in CNT_W: new half-period value.
- `sync_pulse` in 1: global phase realign. Functional only when the configuration macro is defined.
- `divided_clk` out NUM_CH: divided square outputs, registered.
- `tick` out NUM_CH: one-cycle strobe on each toggle of `divided_clk`, registered.

## Operation
- Each channel holds three registers: `half_reg` (CNT_W), `cnt` (CNT_W), and its output bits.
- Reset values when `rst`=1 at a clock edge, for all channels:
  - `half_reg`=DEFAULT_HALF
  - `cnt`=0
  - `divided_clk`=0
  - `tick`=0
  - Reset overrides every other input.
- Run: when `ch_en[i]`=1 and there is no write or sync this cycle:
  - If `cnt`==`half_reg`: `cnt`←0, `divided_clk[i]` toggles, `tick[i]`←1.
  - Otherwise `cnt`←`cnt`+1 and `tick[i]`←0.
- Output period is 2·(`half_reg`+1) cycles. `half_reg`=0 gives divide-by-2, with `tick` asserted every cycle.
- Counter arithmetic: plain CNT_W-bit increment. The counter never exceeds `half_reg`, so it never wraps.
- Disabled (`ch_en[i]`=0):
  - `cnt` and `divided_clk[i]` hold.
  - `tick[i]`←0.
  - Re-enabling resumes from the held count.
- Write, when `cfg_we`=1 and `cfg_ch`<NUM_CH:
  - Target channel: `half_reg`←`cfg_half`, `cnt`←0, `divided_clk` holds its level, `tick`←0.
  - Applies regardless of `ch_en`.
  - Other channels are unaffected.
- A write with `cfg_ch`≥NUM_CH is ignored.
- Write in the same cycle as the terminal count: the write wins. No toggle and no tick occur.
- Priority, highest first: `rst`, sync (when compiled in), write, run/hold.

## Timing
- All outputs are registered, with no combinational path from input to output.
- A write at edge N takes effect at N. The first toggle with the new value occurs at edge N+`cfg_half`+1, given an enabled channel.
- `tick[i]` is high for exactly one cycle, coincident with the cycle in which the new `divided_clk[i]` level first appears.
- Reset released at edge R: the first toggle occurs at edge R+DEFAULT_HALF+1.

## Configuration
- Macro: `TICK_DIVIDER_SYNC_EN`.
- Defined: `sync_pulse`=1 clears `cnt` and `divided_clk` in all channels and forces `tick`←0 in the same edge. `half_reg` is preserved and `ch_en` is ignored for this operation. Sync beats a simultaneous write: the write's `half_reg` update is dropped.
- Undefined: `sync_pulse` is ignored and no sync logic is synthesised. The port remains so instantiations stay identical.

## Structure
- Package `tick_divider_pkg` holds:
  - The `CNT_W` default.
  - The `DEFAULT_HALF` default.
  - The `NUM_CH` limit constant, 16.
  - A typedef for the per-channel count word.
- Sub-module `tick_divider_ch` covers one channel: counter, half-period register, toggle, and tick.
- The top level performs write decode, the `cfg_ch` range check, and sync fan-out, then generate-instantiates `NUM_CH` copies of `tick_divider_ch`.

## Test plan
- Reset with DEFAULT_HALF=3 and all channels enabled → `divided_clk`=0 and `tick`=0 during reset. The first toggle occurs 4 cycles after release, with period 8.
- Write ch1 half=0, then ch2 half=5 → ch1 toggles every cycle with `tick[1]` constantly high. ch2 has period 12. ch0 is undisturbed.
- Hold ch0 with `ch_en[0]`=0 for 10 cycles at `cnt`=2, half=3 → output holds and `tick`=0. After re-enable, the toggle arrives 2 cycles later.
- Write to ch0 on its terminal-count cycle → no toggle and no tick. The new period applies counted from the write edge.
- `cfg_ch`=NUM_CH with `cfg_we`=1 → no channel changes.
- With `TICK_DIVIDER_SYNC_EN`, pulse `sync_pulse` while channels are at mixed phases → all outputs are 0 and all counters are 0 the next cycle. Equal-half channels then toggle in lockstep. Without the macro, the pulse has no effect.
